// File: rtl/systolic_tile_sequencer_if.sv
// Command, X/W stream, array-side and result signals of systolic_tile_sequencer.
// The sequencer uses the slave modport; the upstream/array environment uses master.
interface systolic_tile_sequencer_if #(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 2,
    parameter int CONTEXT_LENGTH = 4,
    parameter int K_MAX          = 256
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int XW = CONTEXT_LENGTH * WIDTH;
    localparam int WW = HIDDEN_SIZE * 2;
    localparam int YW = HIDDEN_SIZE * CONTEXT_LENGTH * 2 * WIDTH;

    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;

    logic          x_valid;
    logic [XW-1:0] x_data;
    logic          x_ready;
    logic          w_valid;
    logic [WW-1:0] w_data;
    logic          w_ready;

    logic          sa_rst;
    logic [XW-1:0] sa_x;
    logic [WW-1:0] sa_w;
    logic [YW-1:0] sa_y;

    logic          y_valid;
    logic          y_ready;
    logic [YW-1:0] y_data;
    logic          done;

    modport slave (
        input  start, k_len, x_valid, x_data, w_valid, w_data, sa_y, y_ready,
        output busy, x_ready, w_ready, sa_rst, sa_x, sa_w, y_valid, y_data, done
    );

    modport master (
        output start, k_len, x_valid, x_data, w_valid, w_data, sa_y, y_ready,
        input  busy, x_ready, w_ready, sa_rst, sa_x, sa_w, y_valid, y_data, done
    );
endinterface

// File: rtl/systolic_tile_sequencer.sv
// Runs one output-stationary tile: clear array, stream paired X/W, drain, hold Y until taken.
// Define SA_SEQ_PERF_EN to add the o_stall_cnt FEED-stall counter output.
module systolic_tile_sequencer #(
    parameter int WIDTH          = 16,
    parameter int HIDDEN_SIZE    = 2,
    parameter int CONTEXT_LENGTH = 4,
    parameter int K_MAX          = 256,
    parameter int DRAIN_CYCLES   = CONTEXT_LENGTH + HIDDEN_SIZE
) (
    input  logic        i_clk,
    input  logic        i_rst,
`ifdef SA_SEQ_PERF_EN
    output logic [31:0] o_stall_cnt,
`endif
    systolic_tile_sequencer_if.slave bus
);
    localparam int KW = $clog2(K_MAX + 1);
    localparam int XW = CONTEXT_LENGTH * WIDTH;
    localparam int WW = HIDDEN_SIZE * 2;
    localparam int YW = HIDDEN_SIZE * CONTEXT_LENGTH * 2 * WIDTH;
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_OUTPUT
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [KW-1:0] r_k_len;
    logic [KW-1:0] r_step_cnt;
    logic [DW-1:0] r_drain_cnt;
    logic [XW-1:0] r_sa_x;
    logic [WW-1:0] r_sa_w;
    logic [YW-1:0] r_y_data;
    logic          r_y_valid;
    logic          r_done;

    logic          w_start_ok;
    logic          w_step;
    logic          w_last_step;
    logic          w_last_drain;
    logic          w_y_fire;

    assign w_start_ok   = (r_state == S_IDLE) && bus.start && (bus.k_len != '0);
    // X and W only ever move together so the array sees matched operands or a matched bubble.
    assign w_step       = (r_state == S_FEED) && bus.x_valid && bus.w_valid;
    assign w_last_step  = w_step && ((r_step_cnt + KW'(1)) == r_k_len);
    assign w_last_drain = (r_state == S_DRAIN) && (r_drain_cnt == DW'(DRAIN_CYCLES - 1));
    assign w_y_fire     = (r_state == S_OUTPUT) && r_y_valid && bus.y_ready;

    // NOTE: default assigned first so every path drives w_state_next and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok)   w_state_next = S_CLEAR;
            S_CLEAR:                    w_state_next = S_FEED;
            S_FEED:   if (w_last_step)  w_state_next = S_DRAIN;
            S_DRAIN:  if (w_last_drain) w_state_next = S_OUTPUT;
            S_OUTPUT: if (w_y_fire)     w_state_next = S_IDLE;
            default:                    w_state_next = S_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_step_cnt  <= '0;
            r_drain_cnt <= '0;
            r_sa_x      <= '0;
            r_sa_w      <= '0;
            r_y_data    <= '0;
            r_y_valid   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_next;

            if (w_start_ok) begin
                r_k_len <= bus.k_len;
            end

            if (r_state == S_CLEAR) begin
                r_step_cnt <= '0;
            end else if (w_step) begin
                r_step_cnt <= r_step_cnt + KW'(1);
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + DW'(1);
            end else begin
                r_drain_cnt <= '0;
            end

            r_sa_x <= w_step ? bus.x_data : '0;
            r_sa_w <= w_step ? bus.w_data : '0;

            if (w_last_drain) begin
                r_y_data <= bus.sa_y;
            end

            if (w_last_drain) begin
                r_y_valid <= 1'b1;
            end else if (w_y_fire) begin
                r_y_valid <= 1'b0;
            end

            r_done <= w_y_fire;
        end
    end

`ifdef SA_SEQ_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_FEED) && !w_step && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

    assign bus.busy    = (r_state != S_IDLE);
    assign bus.x_ready = w_step;
    assign bus.w_ready = w_step;
    assign bus.sa_rst  = i_rst | (r_state == S_CLEAR);
    assign bus.sa_x    = r_sa_x;
    assign bus.sa_w    = r_sa_w;
    assign bus.y_valid = r_y_valid;
    assign bus.y_data  = r_y_data;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// Bench for systolic_tile_sequencer with a behavioural array stub driving sa_y.
module tb_systolic_tile_sequencer;
    localparam int WIDTH  = 16;
    localparam int H      = 2;
    localparam int C      = 4;
    localparam int K_MAX  = 256;
    localparam int KW     = $clog2(K_MAX + 1);
    localparam int DRAIN  = C + H;
    localparam int AW     = 2 * WIDTH;
    localparam int XW     = C * WIDTH;
    localparam int WW     = H * 2;
    localparam int YW     = H * C * AW;
    localparam int SA_LAT = DRAIN - 2;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic [YW-1:0] sb_y[$];
    int            sb_lat[$];

    systolic_tile_sequencer_if #(
        .WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .K_MAX(K_MAX)
    ) bus ();

`ifdef SA_SEQ_PERF_EN
    logic [31:0] stall_cnt;
`endif

    systolic_tile_sequencer #(
        .WIDTH(WIDTH), .HIDDEN_SIZE(H), .CONTEXT_LENGTH(C), .K_MAX(K_MAX), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
`ifdef SA_SEQ_PERF_EN
        .o_stall_cnt(stall_cnt),
`endif
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d, want finish earlier", cyc);
        $fatal(1, "timeout");
    end

    function automatic logic [YW-1:0] mac(input logic [YW-1:0] a, input logic [XW-1:0] x,
                                          input logic [WW-1:0] w);
        logic [YW-1:0] r;
        logic [AW-1:0] xe;
        r = a;
        for (int h = 0; h < H; h++) begin
            for (int c = 0; c < C; c++) begin
                xe = {{WIDTH{x[c*WIDTH + WIDTH - 1]}}, x[c*WIDTH +: WIDTH]};
                if (w[h*2 +: 2] == 2'b01)
                    r[(h*C + c)*AW +: AW] = r[(h*C + c)*AW +: AW] + xe;
                else if (w[h*2 +: 2] == 2'b11)
                    r[(h*C + c)*AW +: AW] = r[(h*C + c)*AW +: AW] - xe;
            end
        end
        return r;
    endfunction

    // Array stub: skew/depth pipeline then accumulate, cleared by sa_rst.
    logic [XW-1:0] d_x[SA_LAT];
    logic [WW-1:0] d_w[SA_LAT];
    logic [YW-1:0] acc;
    assign bus.sa_y = acc;

    always @(posedge clk) begin
        if (bus.sa_rst) begin
            for (int i = 0; i < SA_LAT; i++) begin
                d_x[i] <= '0;
                d_w[i] <= '0;
            end
            acc <= '0;
        end else begin
            d_x[0] <= bus.sa_x;
            d_w[0] <= bus.sa_w;
            for (int i = 1; i < SA_LAT; i++) begin
                d_x[i] <= d_x[i-1];
                d_w[i] <= d_w[i-1];
            end
            acc <= mac(acc, d_x[SA_LAT-1], d_w[SA_LAT-1]);
        end
    end

    function automatic logic [XW-1:0] pack_x(input int a, input int b, input int c, input int d);
        return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
    endfunction

    function automatic logic [1:0] tern(input int v);
        return (v > 0) ? 2'b01 : ((v < 0) ? 2'b11 : 2'b00);
    endfunction

    function automatic logic [WW-1:0] pack_w(input int a, input int b);
        return {tern(b), tern(a)};
    endfunction

    function automatic logic [YW-1:0] ymat(input int v[H*C]);
        logic [YW-1:0] r;
        r = '0;
        for (int i = 0; i < H*C; i++) r[i*AW +: AW] = AW'(v[i]);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int k, output int t0);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        t0 = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic push_step(input logic [XW-1:0] x, input logic [WW-1:0] w, output logic ok);
        bus.x_valid = 1'b1;
        bus.w_valid = 1'b1;
        bus.x_data  = x;
        bus.w_data  = w;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.x_ready === 1'b1 && bus.w_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        bus.x_valid = 1'b0;
        bus.w_valid = 1'b0;
    endtask

    task automatic wait_y(input int budget, output int seen);
        seen = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.y_valid === 1'b1) begin
                seen = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: busy=%b y_valid=%b done=%b, want 0 0 0", bus.busy, bus.y_valid, bus.done);
        end
        tests_run++;
        if (bus.sa_x !== '0 || bus.sa_w !== '0) begin
            tests_failed++;
            $display("FAIL reset_sa: sa_x=%h sa_w=%h, want 0", bus.sa_x, bus.sa_w);
        end
        tests_run++;
        if (bus.y_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_y_data: got %h, want 0", bus.y_data);
        end
        tests_run++;
        if (bus.sa_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_sa_rst: got %b, want 1", bus.sa_rst);
        end
        tests_run++;
        if (bus.x_ready !== 1'b0 || bus.w_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: x_ready=%b w_ready=%b, want 0 0", bus.x_ready, bus.w_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.sa_rst !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: sa_rst=%b, want 0", bus.sa_rst);
        end
    endtask

    task automatic test_single_step();
        int t0, seen;
        logic ok;
        logic [YW-1:0] exp_y;
        int exp_lat;
        int v[H*C];
        tick();
        bus.y_ready = 1'b1;
        v = '{1, 2, 3, 4, -1, -2, -3, -4};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(9);
        start_tile(1, t0);
        tests_run++;
        if (bus.sa_rst !== 1'b1 || bus.busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_clear: sa_rst=%b busy=%b, want 1 1", bus.sa_rst, bus.busy);
        end
        push_step(pack_x(1, 2, 3, 4), pack_w(1, -1), ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_accept: step accepted=%b, want 1", ok);
        end
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat) begin
            tests_failed++;
            $display("FAIL single_latency: y_valid at cycle %0d, want %0d", seen - t0, exp_lat);
        end
        tests_run++;
        if (bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL single_data: got %h want %h", bus.y_data, exp_y);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done_pulse: done=%b one cycle later, want 0", bus.done);
        end
    endtask

    task automatic test_back_to_back();
        int t0, seen, exp_lat;
        logic ok;
        logic [YW-1:0] exp_y;
        int v[H*C];
        tick();
        bus.y_ready = 1'b1;
        v = '{3, 3, 3, 3, 3, 3, 3, 3};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(11);
        v = '{-10, 0, 0, 10, 0, 0, 0, 0};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(10);

        start_tile(3, t0);
        for (int i = 0; i < 3; i++) begin
            push_step(pack_x(1, 1, 1, 1), pack_w(1, 1), ok);
            tests_run++;
            if (ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_a_accept: step %0d accepted=%b, want 1", i, ok);
            end
        end
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat || bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL b2b_a_result: cycle %0d data %h, want cycle %0d data %h", seen - t0, bus.y_data, exp_lat, exp_y);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_a_done: done=%b busy=%b, want 1 0", bus.done, bus.busy);
        end

        start_tile(2, t0);
        for (int i = 0; i < 2; i++) begin
            push_step(pack_x(5, 0, 0, -5), pack_w(-1, 0), ok);
            tests_run++;
            if (ok !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_b_accept: step %0d accepted=%b, want 1", i, ok);
            end
        end
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat) begin
            tests_failed++;
            $display("FAIL b2b_b_latency: y_valid at cycle %0d, want %0d", seen - t0, exp_lat);
        end
        tests_run++;
        if (bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL b2b_b_data: got %h want %h", bus.y_data, exp_y);
        end
        tick();
        tests_run++;
        if (bus.done !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_b_done: done=%b, want 1", bus.done);
        end
    endtask

    task automatic test_stall();
        int t0, seen, exp_lat;
        logic ok;
        logic [YW-1:0] exp_y;
        int v[H*C];
        tick();
        bus.y_ready = 1'b1;
        v = '{-89, 22, 33, 44, -9, -18, -27, -29};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(14);
        start_tile(4, t0);
        push_step(pack_x(1, 2, 3, 4), pack_w(1, 1), ok);
        push_step(pack_x(10, 20, 30, 40), pack_w(1, -1), ok);
        bus.x_valid = 1'b0;
        bus.w_valid = 1'b1;
        bus.x_data  = pack_x(99, 99, 99, 99);
        bus.w_data  = pack_w(1, 1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.x_ready !== 1'b0 || bus.w_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL stall_ready: stall %0d x_ready=%b w_ready=%b, want 0 0", i, bus.x_ready, bus.w_ready);
            end
            tick();
        end
        push_step(pack_x(100, 0, 0, 0), pack_w(-1, 0), ok);
        push_step(pack_x(0, 0, 0, 7), pack_w(0, 1), ok);
        tests_run++;
        if (ok !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_accept: last step accepted=%b, want 1", ok);
        end
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat) begin
            tests_failed++;
            $display("FAIL stall_latency: y_valid at cycle %0d, want %0d", seen - t0, exp_lat);
        end
        tests_run++;
        if (bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL stall_data: got %h want %h", bus.y_data, exp_y);
        end
`ifdef SA_SEQ_PERF_EN
        tests_run++;
        if (stall_cnt !== 32'd2) begin
            tests_failed++;
            $display("FAIL stall_cnt: got %0d want 2", stall_cnt);
        end
`endif
        tick();
    endtask

    task automatic test_backpressure();
        int t0, seen, exp_lat, dones;
        logic ok;
        logic [YW-1:0] exp_y;
        int v[H*C];
        tick();
        bus.y_ready = 1'b0;
        v = '{6, -6, 12, -12, 6, -6, 12, -12};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(10);
        start_tile(2, t0);
        push_step(pack_x(3, -3, 6, -6), pack_w(1, 1), ok);
        push_step(pack_x(3, -3, 6, -6), pack_w(1, 1), ok);
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat || bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL bp_result: cycle %0d data %h, want cycle %0d data %h", seen - t0, bus.y_data, exp_lat, exp_y);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start = 1'b1;
            bus.k_len = KW'(1);
            @(negedge clk);
            tests_run++;
            if (bus.y_valid !== 1'b1 || bus.y_data !== exp_y) begin
                tests_failed++;
                $display("FAIL bp_hold: cycle %0d y_valid=%b data %h, want 1 %h", i, bus.y_valid, bus.y_data, exp_y);
            end
            tests_run++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL bp_wait: cycle %0d done=%b busy=%b, want 0 1", i, bus.done, bus.busy);
            end
        end
        tick();
        bus.start   = 1'b0;
        bus.y_ready = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        tests_run++;
        if (dones !== 1) begin
            tests_failed++;
            $display("FAIL bp_done_count: got %0d pulses want 1", dones);
        end
        tests_run++;
        if (bus.y_valid !== 1'b0 || bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_after: y_valid=%b busy=%b, want 0 0", bus.y_valid, bus.busy);
        end
    endtask

    task automatic test_reset_mid_feed();
        int t0, seen, exp_lat;
        logic ok;
        logic [YW-1:0] exp_y;
        int v[H*C];
        tick();
        bus.y_ready = 1'b1;
        start_tile(4, t0);
        push_step(pack_x(9, 9, 9, 9), pack_w(1, 1), ok);
        push_step(pack_x(9, 9, 9, 9), pack_w(1, 1), ok);
        bus.x_valid = 1'b1;
        bus.w_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.y_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_flags: busy=%b y_valid=%b, want 0 0", bus.busy, bus.y_valid);
        end
        tests_run++;
        if (bus.sa_x !== '0 || bus.sa_w !== '0) begin
            tests_failed++;
            $display("FAIL rstmid_sa: sa_x=%h sa_w=%h, want 0", bus.sa_x, bus.sa_w);
        end
        tests_run++;
        if (bus.sa_rst !== 1'b1 || bus.x_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_ctrl: sa_rst=%b x_ready=%b, want 1 0", bus.sa_rst, bus.x_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.x_valid = 1'b0;
        bus.w_valid = 1'b0;
        tick();
        v = '{-7, 8, -9, 10, 7, -8, 9, -10};
        sb_y.push_back(ymat(v));
        sb_lat.push_back(9);
        start_tile(1, t0);
        push_step(pack_x(7, -8, 9, -10), pack_w(-1, 1), ok);
        wait_y(40, seen);
        exp_y   = sb_y.pop_front();
        exp_lat = sb_lat.pop_front();
        tests_run++;
        if (seen - t0 !== exp_lat) begin
            tests_failed++;
            $display("FAIL rstmid_latency: y_valid at cycle %0d, want %0d", seen - t0, exp_lat);
        end
        tests_run++;
        if (bus.y_data !== exp_y) begin
            tests_failed++;
            $display("FAIL rstmid_data: got %h want %h", bus.y_data, exp_y);
        end
        tick();
    endtask

    task automatic test_degenerate();
        logic activity;
        tick();
        bus.start   = 1'b1;
        bus.k_len   = '0;
        bus.x_valid = 1'b1;
        bus.w_valid = 1'b1;
        activity = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.busy !== 1'b0 || bus.x_ready !== 1'b0 || bus.w_ready !== 1'b0 ||
                bus.y_valid !== 1'b0 || bus.done !== 1'b0) activity = 1'b1;
            tick();
            bus.start = 1'b0;
        end
        bus.x_valid = 1'b0;
        bus.w_valid = 1'b0;
        tests_run++;
        if (activity !== 1'b0) begin
            tests_failed++;
            $display("FAIL degenerate: activity=%b, want 0", activity);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.k_len   = '0;
        bus.x_valid = 1'b0;
        bus.x_data  = '0;
        bus.w_valid = 1'b0;
        bus.w_data  = '0;
        bus.y_ready = 1'b0;

        test_reset();
        test_single_step();
        test_back_to_back();
        test_stall();
        test_backpressure();
        test_reset_mid_feed();
        test_degenerate();

        tests_run++;
        if (sb_y.size() !== 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d results left, want 0", sb_y.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
